// File: rtl/core_pkg.sv
// Shared types and default widths for the bus arbiter slice.
package core_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 32;
    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_pick.sv
// Two-requester contention picker. BUS_ARBITER_ROUND_ROBIN_EN selects round-robin,
// otherwise the data port wins on contention.
module arb_pick
    import core_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  owner_t last_grant,
    output owner_t owner
);

    // Resolve the owner for the current request pair.
    always_comb begin
        owner = OWN_I;
        if (i_req && d_req) begin
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
            owner = (last_grant == OWN_I) ? OWN_D : OWN_I;
`else
            owner = OWN_D;
`endif
        end else if (d_req) begin
            owner = OWN_D;
        end else begin
            owner = OWN_I;
        end
    end

`ifndef BUS_ARBITER_ROUND_ROBIN_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/bus_arbiter.sv
// Fetch/data arbiter onto a single-port memory, one transaction in flight.
// Define BUS_ARBITER_ROUND_ROBIN_EN for round-robin contention (default: data priority).
module bus_arbiter
    import core_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ack,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_t state;
    state_t next_state;
    owner_t owner;
    owner_t last_grant;
    owner_t pick;
    logic   owner_we;
    logic   grant;
    logic   resp_done;

    arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_grant),
        .owner      (pick)
    );

    assign resp_done = (state == RESP);

    // Next-state decode; a grant happens only when leaving IDLE.
    always_comb begin
        next_state = state;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    next_state = ACCESS;
                    grant      = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            ACCESS:  next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register plus the owner and write flag latched at grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= OWN_I;
            owner_we <= 1'b0;
        end else begin
            state <= next_state;
            if (grant) begin
                owner    <= pick;
                owner_we <= (pick == OWN_D) ? d_we : 1'b0;
            end
        end
    end

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    // Remember who won the last grant for round-robin fairness.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= OWN_I;
        end else if (grant) begin
            last_grant <= pick;
        end
    end
`else
    assign last_grant = OWN_I;
`endif

    // Memory strobe is loaded on grant so it is high exactly during ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {ADDR_WIDTH{1'b0}};
            mem_wdata <= {DATA_WIDTH{1'b0}};
        end else if (grant) begin
            mem_en    <= 1'b1;
            mem_we    <= (pick == OWN_D) ? d_we : 1'b0;
            mem_addr  <= (pick == OWN_D) ? d_addr : i_addr;
            mem_wdata <= (pick == OWN_D) ? d_wdata : {DATA_WIDTH{1'b0}};
        end else begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {ADDR_WIDTH{1'b0}};
            mem_wdata <= {DATA_WIDTH{1'b0}};
        end
    end

    // Completion: ack pulse and read-data capture, both leaving RESP together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            i_rdata <= {DATA_WIDTH{1'b0}};
            d_rdata <= {DATA_WIDTH{1'b0}};
        end else begin
            i_ack <= resp_done && (owner == OWN_I);
            d_ack <= resp_done && (owner == OWN_D);
            if (resp_done && (owner == OWN_I)) begin
                i_rdata <= mem_rdata;
            end
            if (resp_done && (owner == OWN_D) && !owner_we) begin
                d_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table, corner sequences, random vs. model.
module tb_bus_arbiter;
    import core_pkg::*;

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = 32'h0, d_addr = 32'h0, d_wdata = 32'h0;
    logic        i_ack, d_ack, mem_en, mem_we;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    logic [31:0] tb_mem  [0:63];
    logic [31:0] ref_mem [0:63];
    logic [31:0] ref_i, ref_d;
    bit          ref_last_d;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        bit          ir;
        logic [31:0] ia;
        bit          dr;
        bit          dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        bit          exp_d;
        logic [31:0] exp_i_rd;
        logic [31:0] exp_d_rd;
    } vec_t;

    vec_t tbl [6];

    bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port memory: read data valid the cycle after mem_en.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) tb_mem[mem_addr[7:2]] <= mem_wdata;
            mem_rdata <= tb_mem[mem_addr[7:2]];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_acks"}, {62'd0, i_ack, d_ack}, 64'd0);
        check({name, "_mem_ctl"}, {62'd0, mem_en, mem_we}, 64'd0);
        check({name, "_mem_addr"}, {32'd0, mem_addr}, 64'd0);
        check({name, "_mem_wdata"}, {32'd0, mem_wdata}, 64'd0);
        check({name, "_rdata"}, {i_rdata, d_rdata}, 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_req = 1'b0; d_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One transaction from idle; owner's ack must appear after the third edge.
    task automatic run_txn(input bit ir, input logic [31:0] ia, input bit dr, input bit dwe,
                           input logic [31:0] da, input logic [31:0] dwd, input bit exp_d,
                           input logic [31:0] exp_i_rd, input logic [31:0] exp_d_rd);
        i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
        @(posedge clk); #1;
        check("access_mem_en", {63'd0, mem_en}, 64'd1);
        check("access_mem_addr", {32'd0, mem_addr}, {32'd0, exp_d ? da : ia});
        check("access_mem_we", {63'd0, mem_we}, {63'd0, exp_d ? dwe : 1'b0});
        check("access_mem_wdata", {32'd0, mem_wdata}, {32'd0, exp_d ? dwd : 32'd0});
        check("access_no_ack", {62'd0, i_ack, d_ack}, 64'd0);
        @(posedge clk); #1;
        check("resp_mem_idle", {31'd0, mem_en, mem_we, mem_addr}, 64'd0);
        check("resp_no_ack", {62'd0, i_ack, d_ack}, 64'd0);
        @(posedge clk); #1;
        check("i_ack", {63'd0, i_ack}, {63'd0, !exp_d});
        check("d_ack", {63'd0, d_ack}, {63'd0, exp_d});
        check("i_rdata", {32'd0, i_rdata}, {32'd0, exp_i_rd});
        check("d_rdata", {32'd0, d_rdata}, {32'd0, exp_d_rd});
        check("done_mem_en", {63'd0, mem_en}, 64'd0);
        i_req = 1'b0; d_req = 1'b0;
    endtask

    initial begin
        bit got [4];
        int n;
        int both_high;
        bit ir, dr, we, own_d;
        logic [31:0] ia, da, wd;

        for (int k = 0; k < 64; k++) begin
            tb_mem[k]  = 32'h1000_0000 + 32'(k) * 32'h0000_0101;
            ref_mem[k] = 32'h1000_0000 + 32'(k) * 32'h0000_0101;
        end
        tb_mem[0] = 32'h11; ref_mem[0] = 32'h11;
        tb_mem[1] = 32'h22; ref_mem[1] = 32'h22;
        tb_mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;

        do_reset();
        #1;
        check_all_zero("reset");

        // Back-to-back contention with both requests held throughout.
        i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h04;
        n = 0; both_high = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            @(posedge clk); #1;
            if (i_ack && d_ack) both_high++;
            if (i_ack || d_ack) begin
                got[n] = d_ack;
                n++;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        check("cont_count", 64'(n), 64'd4);
        check("cont_both_ack", 64'(both_high), 64'd0);
        for (int k = 0; k < 4; k++)
            check("cont_grant_is_d", {63'd0, got[k]}, {63'd0, RR ? ((k % 2) == 0) : 1'b1});

        do_reset();
        tbl[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h80, 32'hA5, 1'b1, 32'hDEADBEEF, 32'h0};
        tbl[2] = '{1'b1, 32'h00, 1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 32'h11,       32'h0};
        tbl[3] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h04, 32'h0,  1'b1, 32'h11,       32'h22};
        tbl[4] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h80, 32'h0,  1'b1, 32'h11,       32'hA5};
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
        tbl[5] = '{1'b1, 32'h10, 1'b1, 1'b0, 32'h00, 32'h0,  1'b0, 32'hDEADBEEF, 32'hA5};
`else
        tbl[5] = '{1'b1, 32'h10, 1'b1, 1'b0, 32'h00, 32'h0,  1'b1, 32'h11,       32'h11};
`endif
        for (int v = 0; v < 6; v++) begin
            run_txn(tbl[v].ir, tbl[v].ia, tbl[v].dr, tbl[v].dwe, tbl[v].da, tbl[v].dwd,
                    tbl[v].exp_d, tbl[v].exp_i_rd, tbl[v].exp_d_rd);
            if (tbl[v].exp_d && tbl[v].dwe) ref_mem[tbl[v].da[7:2]] = tbl[v].dwd;
        end

        // Reset while a fetch is in ACCESS aborts it with no ack.
        i_req = 1'b1; i_addr = 32'h10; d_req = 1'b0;
        @(posedge clk); #1;
        check("abort_mem_en_before", {63'd0, mem_en}, 64'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        @(posedge clk); #1;
        check("abort_no_ack", {62'd0, i_ack, d_ack}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF, 32'h0);

        // Random traffic against a transaction-level model.
        ref_i = 32'hDEADBEEF; ref_d = 32'h0; ref_last_d = 1'b0;
        for (int t = 0; t < 40; t++) begin
            ir = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            if (!ir && !dr) ir = 1'b1;
            we = 1'($urandom_range(0, 1));
            ia = {22'd0, 8'($urandom_range(0, 63)), 2'b00};
            da = {22'd0, 8'($urandom_range(0, 63)), 2'b00};
            wd = $urandom;
            if (ir && dr) own_d = RR ? !ref_last_d : 1'b1;
            else          own_d = dr;
            ref_last_d = own_d;
            if (!own_d)   ref_i = ref_mem[ia[7:2]];
            else if (!we) ref_d = ref_mem[da[7:2]];
            else          ref_mem[da[7:2]] = wd;
            run_txn(ir, ia, dr, we, da, wd, own_d, ref_i, ref_d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width of both requesters and memory port.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-003 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports i_req  input  1 / i_addr  input  ADDR_WIDTH  instruction-fetch read request and address.
REQ-006 SHALL have ports i_ack  output  1 / i_rdata  output  DATA_WIDTH  fetch completion pulse and read data.
REQ-007 SHALL have ports d_req  input  1 / d_we  input  1 / d_addr  input  ADDR_WIDTH / d_wdata  input  DATA_WIDTH  data-port request, write enable, address, write data.
REQ-008 SHALL have ports d_ack  output  1 / d_rdata  output  DATA_WIDTH  data completion pulse and read data.
REQ-009 SHALL have ports mem_en  output  1 / mem_we  output  1 / mem_addr  output  ADDR_WIDTH / mem_wdata  output  DATA_WIDTH / mem_rdata  input  DATA_WIDTH  single-port memory, read data valid one cycle after mem_en.

Function
REQ-010 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; one transaction in flight.
REQ-011 IDLE: if any req sampled high, SHALL latch owner (I or D) and go to ACCESS; else stay.
REQ-012 ACCESS: SHALL assert mem_en=1 for exactly one cycle, mem_addr/mem_we/mem_wdata from owner (mem_we=0 for I); go to RESP.
REQ-013 RESP: SHALL pulse owner's ack for exactly one cycle; on read, capture mem_rdata into owner's rdata register; go to IDLE.
REQ-014 Latency SHALL be fixed: ack high 3 rising edges after the edge where req is first sampled in IDLE.
REQ-015 i_rdata/d_rdata SHALL be registered, change only on that port's read completion, and hold otherwise; writes SHALL leave d_rdata unchanged.
REQ-016 Requesters SHALL hold req/addr/wdata/we stable until ack; arbiter SHALL drive memory from the latched owner only.
REQ-017 A req still high in the cycle after ack SHALL be treated as a new request.
REQ-018 Non-owner ack SHALL stay 0; both acks never high in same cycle.
REQ-019 Outside ACCESS mem_en, mem_we SHALL be 0; mem_addr/mem_wdata SHALL be 0.
REQ-020 Simultaneous i_req and d_req in IDLE SHALL resolve per Configuration; single req always granted.

Reset
REQ-021 rst_n low SHALL immediately force IDLE, owner=I, last-grant=I, i_ack=d_ack=0, mem_en=mem_we=0, mem_addr=mem_wdata=0, i_rdata=d_rdata=0.
REQ-022 Reset during ACCESS/RESP SHALL abort the transaction without ack; mem_en SHALL fall asynchronously.

Configuration
REQ-023 Macro BUS_ARBITER_ROUND_ROBIN_EN defined: on contention SHALL grant the requester not granted last (last-grant register updated each grant).
REQ-024 Macro undefined: on contention SHALL grant D (fixed priority); last-grant register SHALL not be built.

Structure
REQ-025 Shared package core_pkg SHALL hold state enum (IDLE, ACCESS, RESP), owner enum (OWN_I, OWN_D), and default width constants.
REQ-026 Sub-module arb_pick (2-input combinational picker taking reqs and last-grant, returning owner) SHALL encapsulate the contention rule.

Verification
REQ-027 Single fetch: i_req=1, i_addr=0x10, mem returns 0xDEADBEEF -> mem_en one cycle with addr 0x10, i_ack pulse 3 edges later, i_rdata=0xDEADBEEF.
REQ-028 Data write: d_req=1, d_we=1, d_addr=0x80, d_wdata=0x000000A5 -> mem_we=1 with those values one cycle, d_ack pulse, d_rdata unchanged.
REQ-029 Contention x4 back-to-back, both req held: RR build grants D,I,D,I (first D since last-grant=I); fixed build grants D,D,D,D, i_ack never.
REQ-030 Reset asserted in ACCESS of a fetch -> mem_en=0 same cycle, no i_ack, all outputs 0; after release next i_req completes in 3 edges.
REQ-031 Alternating reads I@0x00 then D@0x04 (mem 0x11, 0x22) -> i_rdata=0x11, d_rdata=0x22, each held through the other's transaction.
